switch_out_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one switch output port, shared by NUM_PORTS input ports.
- Each input port presents 8-bit data bytes with a status flag (valid) and a last marker.
- The block grants exactly one input at a time and forwards that input's whole packet to the output.
- It releases the grant only after the last byte or a length-limit cut, then re-arbitrates.

---
 rtl/switch_out_arbiter.sv | 117 +++++++++++
 tb/tb_switch_out_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/switch_out_arbiter.sv
// Round-robin packet arbiter for one output port; grant one cycle after req, data path combinational.
// Backpressure: out_ready passes straight to the granted in_ready; stalls hold state and byte count.
module switch_out_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int MAX_LEN    = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS-1:0]   req,
    input  logic [8*NUM_PORTS-1:0] in_data,
    input  logic [NUM_PORTS-1:0]   in_status,
    input  logic [NUM_PORTS-1:0]   in_last,
    output logic [NUM_PORTS-1:0]   in_ready,
    output logic [NUM_PORTS-1:0]   grant,
    output logic [7:0]             out_data,
    output logic                   out_status,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   err_len
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [7:0] LAST_CNT = 8'(MAX_LEN - 1);
    localparam logic [1:0] GAP_END  = 2'(GAP_CYCLES - 1);

    logic [1:0]    state;
    logic [PW-1:0] gidx;
    logic [PW-1:0] ptr;
    logic [7:0]    cnt;
    logic [1:0]    gap_cnt;

    logic          win_vld;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;
    logic          fire;

    // Walk from farthest to nearest so the port closest after ptr is the final winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % NUM_PORTS);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        out_data   = 8'h00;
        out_status = 1'b0;
        out_last   = 1'b0;
        if (state == S_XFER) begin
            in_ready[gidx] = out_ready;
            out_data       = in_data[{gidx, 3'b000} +: 8];
            out_status     = in_status[gidx];
            out_last       = in_last[gidx] | (cnt == LAST_CNT);
        end
    end

    assign fire = out_status & out_ready;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            grant   <= '0;
            gidx    <= '0;
            ptr     <= PW'(NUM_PORTS - 1);
            cnt     <= 8'h00;
            gap_cnt <= 2'd0;
            err_len <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        grant <= NUM_PORTS'(1) << win_idx;
                        gidx  <= win_idx;
                        ptr   <= win_idx;
                        cnt   <= 8'h00;
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (fire) begin
                        if (out_last) begin
                            grant   <= '0;
                            cnt     <= 8'h00;
                            gap_cnt <= 2'd0;
                            // A cut without a real last leaves the packet tail queued at the source.
                            err_len <= ~in_last[gidx];
                            state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                        end else begin
                            cnt <= cnt + 8'h01;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_END) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed bench: default instance for arbitration/backpressure/reset, MAX_LEN=4 instance for cuts.
module tb_switch_out_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, in_status, in_last, in_ready, grant;
    logic [31:0] in_data;
    logic [7:0]  out_data;
    logic        out_status, out_last, out_ready, busy, err_len;

    logic [3:0]  c_req, c_in_status, c_in_last, c_in_ready, c_grant;
    logic [31:0] c_in_data;
    logic [7:0]  c_out_data;
    logic        c_out_status, c_out_last, c_out_ready, c_busy, c_err_len;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    switch_out_arbiter #(.NUM_PORTS(4), .MAX_LEN(64), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .in_status(in_status),
        .in_last(in_last), .in_ready(in_ready), .grant(grant), .out_data(out_data),
        .out_status(out_status), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .err_len(err_len)
    );

    switch_out_arbiter #(.NUM_PORTS(4), .MAX_LEN(4), .GAP_CYCLES(1)) dut_cut (
        .clk(clk), .rst_n(rst_n), .req(c_req), .in_data(c_in_data), .in_status(c_in_status),
        .in_last(c_in_last), .in_ready(c_in_ready), .grant(c_grant), .out_data(c_out_data),
        .out_status(c_out_status), .out_last(c_out_last), .out_ready(c_out_ready),
        .busy(c_busy), .err_len(c_err_len)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; in_status = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        c_req = '0; c_in_status = '0; c_in_last = '0; c_in_data = '0; c_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111; in_status = 4'b0001; in_last = '0; in_data = 32'h0000_00A1; out_ready = 1'b1;
        c_req = '0; c_in_status = '0; c_in_last = '0; c_in_data = '0; c_out_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b exp=0000", grant); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
        total++; if ({out_status, out_last, busy, err_len} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {out_status, out_last, busy, err_len}); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b exp=0001", grant); end
        total++; if (out_data !== 8'hA1 || out_status !== 1'b1 || out_last !== 1'b0) begin bad++; $display("FAIL byte_a1 got=%h/%b/%b exp=a1/1/0", out_data, out_status, out_last); end
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL first_in_ready got=%b exp=0001", in_ready); end
        @(negedge clk); in_data[7:0] = 8'hA2; #1;
        total++; if (out_data !== 8'hA2 || out_last !== 1'b0) begin bad++; $display("FAIL byte_a2 got=%h/%b exp=a2/0", out_data, out_last); end
        @(negedge clk); in_data[7:0] = 8'hA3; in_last = 4'b0001; #1;
        total++; if (out_data !== 8'hA3 || out_last !== 1'b1) begin bad++; $display("FAIL byte_a3 got=%h/%b exp=a3/1", out_data, out_last); end
        @(negedge clk); in_status = '0; in_last = '0; #1;
        total++; if (grant !== 4'b0000 || busy !== 1'b1 || out_status !== 1'b0) begin bad++; $display("FAIL gap got=%b/%b/%b exp=0000/1/0", grant, busy, out_status); end
        @(negedge clk); #1;
        total++; if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL idle got=%b/%b exp=0000/0", grant, busy); end
        @(negedge clk); #1;
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL second_grant got=%b exp=0010", grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; in_status = 4'b1111; in_last = 4'b1111; in_data = 32'h1312_1110;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            total++; if (grant !== exp_g[i]) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant, exp_g[i]); end
            total++; if (out_data !== in_data[8*i%32 +: 8] || out_last !== 1'b1) begin bad++; $display("FAIL rr_data[%0d] got=%h/%b", i, out_data, out_last); end
            for (int j = 0; j < 2; j++) begin
                total++; if (err_len !== 1'b0) begin bad++; $display("FAIL rr_err[%0d] got=1 exp=0", i); end
                @(negedge clk); #1;
                total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rr_between[%0d] got=%b exp=0000", i, grant); end
            end
        end
    endtask

    task automatic test_backpressure();
        int   sent;
        logic rdy_t;
        sent = 0;
        rdy_t = 1'b1;
        do_reset();
        req = 4'b0100; in_status = 4'b0100;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 20 && sent < 5; cyc++) begin
            @(negedge clk);
            in_data[23:16] = 8'(8'hB0 + sent);
            in_last = (sent == 4) ? 4'b0100 : 4'b0000;
            out_ready = rdy_t;
            #1;
            total++; if (grant !== 4'b0100) begin bad++; $display("FAIL bp_grant[%0d] got=%b exp=0100", cyc, grant); end
            total++; if (in_ready !== {1'b0, rdy_t, 2'b00}) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", cyc, in_ready, {1'b0, rdy_t, 2'b00}); end
            if (rdy_t) begin
                total++; if (out_data !== 8'(8'hB0 + sent) || out_last !== (sent == 4)) begin bad++; $display("FAIL bp_byte[%0d] got=%h/%b exp=%h", sent, out_data, out_last, 8'(8'hB0 + sent)); end
                sent++;
            end
            rdy_t = ~rdy_t;
        end
        @(negedge clk); out_ready = 1'b1; #1;
        total++; if (grant !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL bp_end got=%b/%b exp=0000/1", grant, busy); end
    endtask

    task automatic test_len_cut();
        int   n;
        logic xfer, exp_err;
        n = 0;
        exp_err = 1'b0;
        do_reset();
        c_req = 4'b0010; c_in_status = 4'b0010;
        rst_n = 1'b1;
        // Packet one: bytes 0..3 cut; then GAP, IDLE; packet two: bytes 4..5 with real last.
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge clk);
            c_in_data[15:8] = 8'(8'hC0 + n);
            c_in_last = (n == 5) ? 4'b0010 : 4'b0000;
            #1;
            xfer = (cyc < 4) || (cyc == 6) || (cyc == 7);
            exp_err = (cyc == 4);
            total++; if (c_err_len !== exp_err) begin bad++; $display("FAIL cut_err[%0d] got=%b exp=%b", cyc, c_err_len, exp_err); end
            total++; if (c_grant !== (xfer ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL cut_grant[%0d] got=%b", cyc, c_grant); end
            if (xfer) begin
                total++; if (c_out_data !== 8'(8'hC0 + n) || c_out_last !== (n == 3 || n == 5)) begin bad++; $display("FAIL cut_byte[%0d] got=%h/%b", n, c_out_data, c_out_last); end
                n++;
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b1000; in_status = 4'b1000; in_data[31:24] = 8'hD0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (grant !== 4'b1000 || out_data !== 8'hD0) begin bad++; $display("FAIL mid_grant got=%b/%h exp=1000/d0", grant, out_data); end
        @(negedge clk); in_data[31:24] = 8'hD1; #1;
        total++; if (out_data !== 8'hD1 || busy !== 1'b1) begin bad++; $display("FAIL mid_byte2 got=%h/%b exp=d1/1", out_data, busy); end
        rst_n = 1'b0; #1;
        total++; if ({grant, out_status, busy, err_len, out_last} !== 8'h00) begin bad++; $display("FAIL mid_drop got=%b/%b/%b/%b/%b", grant, out_status, busy, err_len, out_last); end
        @(negedge clk); req = 4'b1001; in_status = 4'b1001; in_data[7:0] = 8'hE0; #1;
        rst_n = 1'b1;
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL mid_err got=1 exp=0"); end
        @(negedge clk); #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_regrant got=%b exp=0001", grant); end
    endtask

    task automatic test_req_pulse();
        do_reset();
        req = 4'b0001; in_status = 4'b0001; in_data[7:0] = 8'h50;
        rst_n = 1'b1;
        @(negedge clk); req = 4'b0011; #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL pulse_grant got=%b exp=0001", grant); end
        @(negedge clk); req = 4'b0000; in_data[7:0] = 8'h51; in_last = 4'b0001; #1;
        total++; if (grant !== 4'b0001 || out_last !== 1'b1) begin bad++; $display("FAIL pulse_hold got=%b/%b exp=0001/1", grant, out_last); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); in_status = '0; in_last = '0; #1;
            total++; if (grant !== 4'b0000) begin bad++; $display("FAIL pulse_nogrant[%0d] got=%b exp=0000", i, grant); end
        end
        @(negedge clk); req = 4'b0010; #1;
        total++; if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL pulse_idle got=%b/%b exp=0000/0", grant, busy); end
        @(negedge clk); #1;
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL pulse_late got=%b exp=0010", grant); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_len_cut();
        test_mid_reset();
        test_req_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
